dm_access_unit: RTL and testbench

//  MEM-stage responder for the data-memory request carried out of the EX/MEM pipeline register (DMWr/DMRe/ALUResult/DataIn).

---
 rtl/dm_access_unit_if.sv | 22 ++
 rtl/dm_access_unit.sv | 155 +++++++++++++++
 tb/tb_dm_access_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_unit_if.sv
// Word-wide req/ack data-memory port shared by the MEM-stage access unit (master) and the memory (slave).
interface dm_access_unit_if #(
  parameter int MEM_AW = 10
);
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dm_access_unit.sv
// MEM-stage data-memory access unit: byte/half/word loads and stores as word transactions on a req/ack port.
// Latency IDLE->BUSY->DONE, min 3 cycles (2 stalled); MemStall holds the pipeline until the memory acks.
module dm_access_unit #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  DMWr,
  input  logic [2:0]  DMRe,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MemStall,
  output logic        MisalignErr,
  dm_access_unit_if.master mem_if
);
  localparam logic [1:0] DMWR_NOP = 2'd0, DMWR_SW = 2'd1, DMWR_SH = 2'd2, DMWR_SB = 2'd3;
  localparam logic [2:0] DMRE_NOP = 3'd0, DMRE_LB = 3'd2, DMRE_LH = 3'd3,
                         DMRE_LBU = 3'd4, DMRE_LHU = 3'd5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              misalign_err_q, misalign_err_d;
  logic [2:0]        ld_op_q, ld_op_d;
  logic [1:0]        ld_off_q, ld_off_d;

  logic        is_store, live, is_half, is_word, misalign;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^Addr[31:MEM_AW+2];

  // Request decode; a store takes priority over a simultaneous load.
  always_comb begin
    is_store = (DMWr != DMWR_NOP);
    live     = is_store || (DMRe != DMRE_NOP);
    is_half  = is_store ? (DMWr == DMWR_SH) : (DMRe == DMRE_LH || DMRe == DMRE_LHU);
    is_word  = is_store ? (DMWr == DMWR_SW)
                        : !(DMRe == DMRE_LB || DMRe == DMRE_LBU || DMRe == DMRE_LH || DMRe == DMRE_LHU);
    misalign = (is_word && (Addr[1:0] != 2'b00)) || (is_half && Addr[0]);
    st_wstrb = 4'b0000;
    st_wdata = DataIn;
    case (DMWr)
      DMWR_SB: begin
        st_wstrb = 4'b0001 << Addr[1:0];
        st_wdata = {4{DataIn[7:0]}};
      end
      DMWR_SH: begin
        st_wstrb = Addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{DataIn[15:0]}};
      end
      DMWR_SW: st_wstrb = 4'b1111;
      default: st_wstrb = 4'b0000;
    endcase
  end

  always_comb begin
    rd_byte = mem_if.mem_rdata[{ld_off_q, 3'b000} +: 8];
    rd_half = ld_off_q[1] ? mem_if.mem_rdata[31:16] : mem_if.mem_rdata[15:0];
    case (ld_op_q)
      DMRE_LB:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      DMRE_LBU: ld_ext = {24'h0, rd_byte};
      DMRE_LH:  ld_ext = {{16{rd_half[15]}}, rd_half};
      DMRE_LHU: ld_ext = {16'h0, rd_half};
      default:  ld_ext = mem_if.mem_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wstrb_d    = mem_wstrb_q;
    mem_wdata_d    = mem_wdata_q;
    data_out_d     = data_out_q;
    misalign_err_d = 1'b0;
    ld_op_d        = ld_op_q;
    ld_off_d       = ld_off_q;
    MemStall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (live && misalign) begin
          misalign_err_d = 1'b1;
        end else if (live) begin
          MemStall    = 1'b1;
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = is_store;
          mem_addr_d  = Addr[MEM_AW+1:2];
          mem_wstrb_d = is_store ? st_wstrb : 4'b0000;
          mem_wdata_d = is_store ? st_wdata : 32'h0;
          ld_op_d     = is_store ? DMRE_NOP : DMRe;
          ld_off_d    = Addr[1:0];
        end
      end
      BUSY: begin
        MemStall = 1'b1;
        if (mem_if.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (!mem_we_q) data_out_d = ld_ext;
        end
      end
      // EX/MEM still presents the finished op here, so it must not be re-issued.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wstrb_q    <= 4'b0000;
      mem_wdata_q    <= 32'h0;
      data_out_q     <= 32'h0;
      misalign_err_q <= 1'b0;
      ld_op_q        <= DMRE_NOP;
      ld_off_q       <= 2'b00;
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wstrb_q    <= mem_wstrb_d;
      mem_wdata_q    <= mem_wdata_d;
      data_out_q     <= data_out_d;
      misalign_err_q <= misalign_err_d;
      ld_op_q        <= ld_op_d;
      ld_off_q       <= ld_off_d;
    end
  end

  assign DataOut          = data_out_q;
  assign MisalignErr      = misalign_err_q;
  assign mem_if.mem_req   = mem_req_q;
  assign mem_if.mem_we    = mem_we_q;
  assign mem_if.mem_addr  = mem_addr_q;
  assign mem_if.mem_wstrb = mem_wstrb_q;
  assign mem_if.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit: stimulus queues expected transactions, load results and
// misalign pulses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_dm_access_unit;
  localparam int AW = 10;
  localparam logic [1:0] W_NOP = 2'd0, W_SW = 2'd1, W_SH = 2'd2, W_SB = 2'd3;
  localparam logic [2:0] R_NOP = 3'd0, R_LW = 3'd1, R_LB = 3'd2, R_LH = 3'd3, R_LBU = 3'd4, R_LHU = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  DMWr = W_NOP;
  logic [2:0]  DMRe = R_NOP;
  logic [31:0] Addr = 32'h0;
  logic [31:0] DataIn = 32'h0;
  logic [31:0] DataOut;
  logic        MemStall;
  logic        MisalignErr;

  dm_access_unit_if #(.MEM_AW(AW)) mif();

  dm_access_unit #(.MEM_AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .DMWr        (DMWr),
    .DMRe        (DMRe),
    .Addr        (Addr),
    .DataIn      (DataIn),
    .DataOut     (DataOut),
    .MemStall    (MemStall),
    .MisalignErr (MisalignErr),
    .mem_if      (mif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    wstrb;
    logic [31:0]   wdata;
  } txn_t;

  int          checks = 0;
  int          failures = 0;
  txn_t        txn_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mis_q[$];
  logic [31:0] exp_do = 32'h0;

  bit          mem_en = 1'b1;
  bit          stray_ack = 1'b0;
  int          lat = 1;
  logic [31:0] rdata_v = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_txn(input string tag, input txn_t e);
    check({tag, "_we"}, 32'(mif.mem_we), 32'(e.we));
    check({tag, "_addr"}, 32'(mif.mem_addr), 32'(e.addr));
    check({tag, "_wstrb"}, 32'(mif.mem_wstrb), 32'(e.wstrb));
    if (e.we) check({tag, "_wdata"}, mif.mem_wdata, e.wdata);
  endtask

  // Memory model: ack 'lat' cycles after mem_req is seen; manual ack when disabled.
  initial begin
    int mcnt;
    mcnt = 0;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_en) begin
        mif.mem_ack = stray_ack;
        mif.mem_rdata = rdata_v;
        mcnt = 0;
      end else if (mif.mem_ack) begin
        mif.mem_ack = 1'b0;
        mcnt = 0;
      end else if (mif.mem_req) begin
        mcnt++;
        if (mcnt >= lat) begin
          mif.mem_ack = 1'b1;
          mif.mem_rdata = rdata_v;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    bit   prev_req;
    bit   prev_we;
    bit   have_cur;
    txn_t cur;
    prev_req = 1'b0;
    prev_we = 1'b0;
    have_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
        have_cur = 1'b0;
      end else begin
        if (mif.mem_req && !prev_req) begin
          if (txn_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_txn: got we=%b addr=%h wstrb=%b, none expected",
                     mif.mem_we, mif.mem_addr, mif.mem_wstrb);
          end else begin
            cur = txn_q.pop_front();
            have_cur = 1'b1;
            check_txn("txn", cur);
          end
        end else if (mif.mem_req && have_cur) begin
          check_txn("txn_hold", cur);
        end
        if (!mif.mem_req && prev_req && !prev_we) begin
          if (rd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_read_done: got DataOut %h, none expected", DataOut);
          end else begin
            check("load_data", DataOut, rd_q.pop_front());
          end
        end
        if (MisalignErr) begin
          if (mis_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_misalign: got MisalignErr 1 expected 0");
          end else begin
            check("misalign_dataout", DataOut, mis_q.pop_front());
          end
        end
        prev_req = mif.mem_req;
        prev_we = mif.mem_we;
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] wr, input logic [2:0] re,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd, input int l,
                        input bit mis, input logic e_we, input logic [AW-1:0] e_addr,
                        input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
                        input bit has_rd, input logic [31:0] e_do);
    int stall;
    int exp_stall;
    lat = l;
    rdata_v = rd;
    exp_stall = mis ? 0 : l + 1;
    if (mis) begin
      mis_q.push_back(exp_do);
    end else begin
      txn_q.push_back({e_we, e_addr, e_wstrb, e_wdata});
      if (has_rd) begin
        rd_q.push_back(e_do);
        exp_do = e_do;
      end
    end
    @(posedge clk);
    #1;
    DMWr = wr;
    DMRe = re;
    Addr = a;
    DataIn = d;
    stall = 0;
    while (1) begin
      @(negedge clk);
      if (!MemStall) break;
      stall++;
      if (stall >= 60) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout: got stall >= %0d cycles expected %0d", name, stall, exp_stall);
        break;
      end
    end
    check({name, "_stall"}, stall, exp_stall);
    if (!mis) check({name, "_done_req"}, 32'(mif.mem_req), 32'd0);
    @(posedge clk);
    #1;
    DMWr = W_NOP;
    DMRe = R_NOP;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_dataout", DataOut, 32'h0);
    check("rst_req", 32'(mif.mem_req), 32'd0);
    check("rst_we", 32'(mif.mem_we), 32'd0);
    check("rst_addr", 32'(mif.mem_addr), 32'd0);
    check("rst_wstrb", 32'(mif.mem_wstrb), 32'd0);
    check("rst_wdata", mif.mem_wdata, 32'h0);
    check("rst_misalign", 32'(MisalignErr), 32'd0);
    check("rst_stall", 32'(MemStall), 32'd0);

    // Stores
    run_op("sw_10", W_SW, R_NOP, 32'h10, 32'hDEADBEEF, 32'h0, 2, 0, 1'b1, 10'h004, 4'b1111, 32'hDEADBEEF, 0, 32'h0);
    run_op("sw_hiaddr", W_SW, R_NOP, 32'hFFFFF3FC, 32'h0BADF00D, 32'h0, 1, 0, 1'b1, 10'h0FF, 4'b1111, 32'h0BADF00D, 0, 32'h0);
    run_op("sb_13", W_SB, R_NOP, 32'h13, 32'h000000A5, 32'h0, 1, 0, 1'b1, 10'h004, 4'b1000, 32'hA5A5A5A5, 0, 32'h0);
    run_op("sb_10", W_SB, R_NOP, 32'h10, 32'hFFFFFF3C, 32'h0, 1, 0, 1'b1, 10'h004, 4'b0001, 32'h3C3C3C3C, 0, 32'h0);
    run_op("sh_12", W_SH, R_NOP, 32'h12, 32'h00001234, 32'h0, 1, 0, 1'b1, 10'h004, 4'b1100, 32'h12341234, 0, 32'h0);
    run_op("sh_10", W_SH, R_NOP, 32'h10, 32'hABCD5678, 32'h0, 1, 0, 1'b1, 10'h004, 4'b0011, 32'h56785678, 0, 32'h0);

    // Loads from a fixed word 0x80FF7F01
    run_op("lb_23", W_NOP, R_LB, 32'h23, 32'h0, 32'h80FF7F01, 1, 0, 1'b0, 10'h008, 4'b0000, 32'h0, 1, 32'hFFFFFF80);
    run_op("lbu_27", W_NOP, R_LBU, 32'h27, 32'h0, 32'h80FF7F01, 1, 0, 1'b0, 10'h009, 4'b0000, 32'h0, 1, 32'h00000080);
    run_op("lh_22", W_NOP, R_LH, 32'h22, 32'h0, 32'h80FF7F01, 2, 0, 1'b0, 10'h008, 4'b0000, 32'h0, 1, 32'hFFFF80FF);
    run_op("lhu_20", W_NOP, R_LHU, 32'h20, 32'h0, 32'h80FF7F01, 1, 0, 1'b0, 10'h008, 4'b0000, 32'h0, 1, 32'h00007F01);
    run_op("lw_24", W_NOP, R_LW, 32'h24, 32'h0, 32'h80FF7F01, 3, 0, 1'b0, 10'h009, 4'b0000, 32'h0, 1, 32'h80FF7F01);
    run_op("lb_21", W_NOP, R_LB, 32'h21, 32'h0, 32'h80FF7F01, 1, 0, 1'b0, 10'h008, 4'b0000, 32'h0, 1, 32'h0000007F);

    // Misaligned: dropped, no stall, one-cycle error pulse
    run_op("mis_lw6", W_NOP, R_LW, 32'h6, 32'h0, 32'h0, 1, 1, 1'b0, 10'h0, 4'b0, 32'h0, 0, 32'h0);
    run_op("mis_lh5", W_NOP, R_LH, 32'h5, 32'h0, 32'h0, 1, 1, 1'b0, 10'h0, 4'b0, 32'h0, 0, 32'h0);
    run_op("mis_sw2", W_SW, R_NOP, 32'h2, 32'h11111111, 32'h0, 1, 1, 1'b0, 10'h0, 4'b0, 32'h0, 0, 32'h0);
    run_op("mis_sh3", W_SH, R_NOP, 32'h3, 32'h22222222, 32'h0, 1, 1, 1'b0, 10'h0, 4'b0, 32'h0, 0, 32'h0);
    check("mis_keep_dataout", DataOut, exp_do);

    // Store and load together: only the store is issued
    run_op("sw_lw", W_SW, R_LW, 32'h20, 32'h11223344, 32'hCAFEF00D, 1, 0, 1'b1, 10'h008, 4'b1111, 32'h11223344, 0, 32'h0);
    check("sw_lw_dataout", DataOut, exp_do);

    // Reset while BUSY, then a stray ack
    lat = 1000;
    rdata_v = 32'h55555555;
    txn_q.push_back({1'b0, 10'h00C, 4'b0000, 32'h0});
    @(posedge clk);
    #1;
    DMRe = R_LW;
    Addr = 32'h30;
    repeat (3) @(negedge clk);
    check("busy_stall", 32'(MemStall), 32'd1);
    check("busy_req", 32'(mif.mem_req), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    DMRe = R_NOP;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_do = 32'h0;
    @(negedge clk);
    check("midrst_req", 32'(mif.mem_req), 32'd0);
    check("midrst_dataout", DataOut, 32'h0);
    check("midrst_stall", 32'(MemStall), 32'd0);
    check("midrst_addr", 32'(mif.mem_addr), 32'd0);
    mem_en = 1'b0;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_req", 32'(mif.mem_req), 32'd0);
      check("stray_dataout", DataOut, 32'h0);
      check("stray_misalign", 32'(MisalignErr), 32'd0);
      check("stray_stall", 32'(MemStall), 32'd0);
    end
    mem_en = 1'b1;

    // Normal operation resumes after reset
    run_op("lw_after_rst", W_NOP, R_LW, 32'h4, 32'h0, 32'h00001234, 3, 0, 1'b0, 10'h001, 4'b0000, 32'h0, 1, 32'h00001234);

    repeat (3) @(negedge clk);
    check("txn_q_empty", txn_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("mis_q_empty", mis_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1);
  end
endmodule
